// File: rtl/logo_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : logo_kbd_pkg
// Purpose : Shared constants and state types for the LOGO keyboard command
//           controller: PS/2 set-2 control scancodes, line-buffer depth and
//           the main / prefix state enumerations.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package logo_kbd_pkg;

  // Line buffer depth; four 8-bit characters fill one 32-bit command word.
  localparam int unsigned MAX_CHARS = 4;

  // PS/2 set-2 scancodes with special meaning to the controller.
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXTEND = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_SEND    = 1'b1
  } main_state_e;

  typedef enum logic [1:0] {
    PFX_NONE    = 2'd0,
    PFX_BRK     = 2'd1,
    PFX_EXT     = 2'd2,
    PFX_EXT_BRK = 2'd3
  } prefix_state_e;

endpackage : logo_kbd_pkg
`default_nettype wire

// File: rtl/scancode_to_ascii.sv
`default_nettype none
// ============================================================================
// Module  : scancode_to_ascii
// Purpose : Combinational decode of a PS/2 set-2 make code into a printable
//           ASCII character or one of the line-editing controls.
// Ports   : code      in  8  make code
//           is_print  out 1  code is a printable key (A-H, 0-9)
//           is_enter  out 1  code is Enter
//           is_bksp   out 1  code is Backspace
//           is_esc    out 1  code is Escape
//           ascii     out 8  ASCII of a printable key, 0 otherwise
// Revision: 1.0  initial release
// ============================================================================
module scancode_to_ascii
  import logo_kbd_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_print,
  output logic       is_enter,
  output logic       is_bksp,
  output logic       is_esc,
  output logic [7:0] ascii
);

  always_comb begin
    is_print = 1'b1;
    ascii    = 8'h00;
    case (code)
      8'h1C: ascii = 8'h41;  // A
      8'h32: ascii = 8'h42;  // B
      8'h21: ascii = 8'h43;  // C
      8'h23: ascii = 8'h44;  // D
      8'h24: ascii = 8'h45;  // E
      8'h2B: ascii = 8'h46;  // F
      8'h34: ascii = 8'h47;  // G
      8'h33: ascii = 8'h48;  // H
      8'h45: ascii = 8'h30;  // 0
      8'h16: ascii = 8'h31;  // 1
      8'h1E: ascii = 8'h32;  // 2
      8'h26: ascii = 8'h33;  // 3
      8'h25: ascii = 8'h34;  // 4
      8'h2E: ascii = 8'h35;  // 5
      8'h36: ascii = 8'h36;  // 6
      8'h3D: ascii = 8'h37;  // 7
      8'h3E: ascii = 8'h38;  // 8
      8'h46: ascii = 8'h39;  // 9
      default: is_print = 1'b0;
    endcase
    is_enter = (code == SC_ENTER);
    is_bksp  = (code == SC_BKSP);
    is_esc   = (code == SC_ESC);
  end

endmodule : scancode_to_ascii
`default_nettype wire

// File: rtl/logo_command_controller.sv
`default_nettype none
// ============================================================================
// Module  : logo_command_controller
// Purpose : Turns PS/2 scancode strobes into 4-character LOGO command words.
//           Filters break/extended sequences, edits a line buffer
//           (append / backspace / clear), offers the line over valid/ready on
//           Enter and echoes every accepted character to the LCD.
// Ports   : clock, resetn            clock, async active-low reset
//           ps2_key_pressed/_data    scancode strobe and byte
//           cmd_data/valid/ready     command word handshake
//           char_count               characters buffered (0..MAX_CHARS)
//           lcd_write_en/_data       one-cycle echo strobe and held ASCII
//           overrun                  one-cycle pulse on a dropped make code
// Revision: 1.0  initial release
// ============================================================================
module logo_command_controller #(
  parameter int unsigned MAX_CHARS = logo_kbd_pkg::MAX_CHARS
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   ps2_key_pressed,
  input  logic [7:0]             ps2_key_data,
  output logic [8*MAX_CHARS-1:0] cmd_data,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [2:0]             char_count,
  output logic                   lcd_write_en,
  output logic [7:0]             lcd_write_data,
  output logic                   overrun
);
  import logo_kbd_pkg::*;

  localparam int unsigned BUF_W      = 8 * MAX_CHARS;
  localparam logic [2:0]  FULL_COUNT = 3'(MAX_CHARS);

  main_state_e        state_q, state_d;
  prefix_state_e      prefix_q, prefix_d;
  logic [BUF_W-1:0]   buffer_q, buffer_d;
  logic [2:0]         count_q, count_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               lcd_en_q, lcd_en_d;
  logic [7:0]         lcd_data_q, lcd_data_d;
  logic               overrun_q, overrun_d;

  logic               is_make;
  logic               key_print, key_enter, key_bksp, key_esc;
  logic [7:0]         key_ascii;

  scancode_to_ascii u_map (
    .code     (ps2_key_data),
    .is_print (key_print),
    .is_enter (key_enter),
    .is_bksp  (key_bksp),
    .is_esc   (key_esc),
    .ascii    (key_ascii)
  );

  always_comb begin
    state_d     = state_q;
    prefix_d    = prefix_q;
    buffer_d    = buffer_q;
    count_d     = count_q;
    lcd_en_d    = 1'b0;
    lcd_data_d  = lcd_data_q;
    overrun_d   = 1'b0;
    is_make     = 1'b0;

    // Prefix tracker runs independently of the main state; any byte that
    // follows a prefix is swallowed and returns the tracker to idle.
    if (ps2_key_pressed) begin
      case (prefix_q)
        PFX_NONE: begin
          if (ps2_key_data == SC_BREAK)       prefix_d = PFX_BRK;
          else if (ps2_key_data == SC_EXTEND) prefix_d = PFX_EXT;
          else                                is_make  = 1'b1;
        end
        PFX_EXT: begin
          if (ps2_key_data == SC_BREAK) prefix_d = PFX_EXT_BRK;
          else                          prefix_d = PFX_NONE;
        end
        default: prefix_d = PFX_NONE;
      endcase
    end

    if (state_q == ST_SEND) begin
      if (cmd_valid_q && cmd_ready) begin
        state_d  = ST_COLLECT;
        buffer_d = '0;
        count_d  = 3'd0;
      end
      // The line is frozen while offered, so any make code is lost.
      if (is_make) overrun_d = 1'b1;
    end else if (is_make) begin
      if (key_print) begin
        if (count_q < FULL_COUNT) begin
          buffer_d   = {buffer_q[BUF_W-9:0], key_ascii};
          count_d    = count_q + 3'd1;
          lcd_en_d   = 1'b1;
          lcd_data_d = key_ascii;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (key_bksp) begin
        if (count_q != 3'd0) begin
          buffer_d = {8'h00, buffer_q[BUF_W-1:8]};
          count_d  = count_q - 3'd1;
        end
      end else if (key_esc) begin
        buffer_d = '0;
        count_d  = 3'd0;
      end else if (key_enter) begin
        if (count_q != 3'd0) state_d = ST_SEND;
      end
    end

    cmd_valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_COLLECT;
      prefix_q    <= PFX_NONE;
      buffer_q    <= '0;
      count_q     <= 3'd0;
      cmd_valid_q <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prefix_q    <= prefix_d;
      buffer_q    <= buffer_d;
      count_q     <= count_d;
      cmd_valid_q <= cmd_valid_d;
      lcd_en_q    <= lcd_en_d;
      lcd_data_q  <= lcd_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_data       = buffer_q;
  assign cmd_valid      = cmd_valid_q;
  assign char_count     = count_q;
  assign lcd_write_en   = lcd_en_q;
  assign lcd_write_data = lcd_data_q;
  assign overrun        = overrun_q;

endmodule : logo_command_controller
`default_nettype wire
